// File: rtl/iob_slot_sched.sv
// Round-robin time-slot scheduler: one requester at a time owns the resource
// for len+1 enabled cycles or until it drops its request.
module iob_slot_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   len_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [ID_W-1:0]           gnt_id_o,
  output logic                      busy_o,
  output logic [DATA_W-1:0]         cnt_o,
  output logic                      slot_end_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [ID_W:0]      N_L     = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(N_REQ-1);
  localparam logic [N_REQ-1:0]   ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   len_q, len_d;
  logic                busy_q, busy_d;

  logic                sel_found_s;
  logic [ID_W-1:0]     sel_id_s;
  logic [DATA_W-1:0]   sel_len_s;
  logic                slot_end_s;

  // Winner search: scan offsets from ptr upward with wrap; descending loop
  // lets the smallest offset overwrite the others.
  always_comb begin
    logic [ID_W:0]   sum_v;
    logic [ID_W-1:0] idx_v;
    sel_found_s = 1'b0;
    sel_id_s    = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      sum_v = {1'b0, ptr_q} + (ID_W+1)'(k);
      idx_v = (sum_v >= N_L) ? ID_W'(sum_v - N_L) : ID_W'(sum_v);
      if (req_i[idx_v]) begin
        sel_found_s = 1'b1;
        sel_id_s    = idx_v;
      end else begin
        sel_found_s = sel_found_s;
        sel_id_s    = sel_id_s;
      end
    end
  end

  // Slot length of the selected winner.
  always_comb begin
    sel_len_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == sel_id_s) begin
        sel_len_s = len_i[i*DATA_W +: DATA_W];
      end else begin
        sel_len_s = sel_len_s;
      end
    end
  end

  // Slot end: expiry or early release, only while granted and enabled.
  always_comb begin
    if (rst_n_i && en_i && (state_q == ST_GRANT)) begin
      slot_end_s = (cnt_q == len_q) || !req_i[gnt_id_q];
    end else begin
      slot_end_s = 1'b0;
    end
  end

  // Next-state logic; ptr always equals (last grant + 1) mod N_REQ, and a
  // releasing requester's bit is already low, so the search needs no mask.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i && sel_found_s) begin
          state_d  = ST_GRANT;
          gnt_d    = ONE_HOT << sel_id_s;
          gnt_id_d = sel_id_s;
          ptr_d    = (sel_id_s == LAST_ID) ? '0 : sel_id_s + ID_W'(1);
          len_d    = sel_len_s;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!en_i) begin
          state_d = ST_GRANT;
        end else if (!slot_end_s) begin
          cnt_d = cnt_q + DATA_W'(1);
        end else if (sel_found_s) begin
          cnt_d    = '0;
          gnt_d    = ONE_HOT << sel_id_s;
          gnt_id_d = sel_id_s;
          ptr_d    = (sel_id_s == LAST_ID) ? '0 : sel_id_s + ID_W'(1);
          len_d    = sel_len_s;
        end else begin
          cnt_d   = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_id_o   = gnt_id_q;
  assign busy_o     = busy_q;
  assign cnt_o      = cnt_q;
  assign slot_end_o = slot_end_s;

endmodule

// File: doc/iob_slot_sched.md
# iob_slot_sched

Round-robin time-slot scheduler that shares one modulo-counted time base among `N_REQ` requesters. Each granted requester owns the resource for a programmable slot of `len+1` enabled cycles, or until it releases early. On each slot end the grant advances to the next requester in round-robin order. The block sits in front of any shared datapath, such as a bus port or a compute unit, that must be time-multiplexed with bounded per-client occupancy.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, must be ≥ 2.
- `DATA_W`, 16: slot-length and counter width.
- `ID_W`, $clog2(N_REQ): localparam, grant index width.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `en_i`  in  1  global enable; when low, all state freezes.
- `req_i`  in  N_REQ  request vector; bit i = requester i.
- `len_i`  in  N_REQ*DATA_W  slot length minus one for requester i, at bits [i*DATA_W +: DATA_W].
- `gnt_o`  out  N_REQ  one-hot grant, registered; all-zero when idle.
- `gnt_id_o`  out  ID_W  index of the current or last grant, registered.
- `busy_o`  out  1  high while in GRANT.
- `cnt_o`  out  DATA_W  cycle count within the current slot, registered.
- `slot_end_o`  out  1  combinational; high in the final cycle of a slot.

## Operation
- Reset (`rst_n_i`=0 at an edge) forces these values: state IDLE, `gnt_o`=0, `gnt_id_o`=0, `busy_o`=0, `cnt_o`=0, round-robin pointer `ptr`=0, latched length `len_r`=0.
- Two states: IDLE and GRANT.
- **Selection.** The winner is the lowest index ≥ `ptr` with its `req_i` bit high. If none exists, the search wraps to index 0 and continues upward. `ptr` = (`gnt_id_o`+1) mod `N_REQ` after any grant, and 0 after reset.
- **IDLE.** If `en_i` is high and `req_i` is non-zero:
  - select the winner, load `gnt_o`/`gnt_id_o`, set `len_r` = `len_i`[winner] and `cnt_o`=0;
  - go to GRANT.
- **GRANT, `en_i` high.**
  - `slot_end_o` = (`cnt_o`==`len_r`) OR (`req_i`[`gnt_id_o`]==0), i.e. the slot expired or the requester released early.
  - If `slot_end_o` is low, `cnt_o` increments by 1.
  - If `slot_end_o` is high, `cnt_o` returns to 0. Selection is then re-run with `ptr`=`gnt_id_o`+1 on the current `req_i`, with the ending requester's bit masked if it released early.
    - If a winner exists: back-to-back grant with no idle cycle; load the new `gnt_o`/`gnt_id_o`/`len_r` and stay in GRANT. A sole continuing requester is regranted to itself.
    - If no winner exists: `gnt_o`=0, `busy_o`=0, go to IDLE. `gnt_id_o` holds its value.
- **GRANT, `en_i` low.** State, `cnt_o` and `gnt_o` all hold. `slot_end_o`=0.
- `slot_end_o` is always 0 in IDLE.
- **Length latching.** `len_i` is sampled only at grant load. Changes mid-slot are ignored.
- **Slot length bounds.** `len`=0 gives a 1-cycle slot. The maximum `len`=2^DATA_W−1 gives a 2^DATA_W-cycle slot; `cnt_o` reaches all-ones and then returns to 0 with no overflow.
- **Reset priority.** Reset mid-slot aborts immediately, with no `slot_end_o` pulse; the reset values above apply on the next cycle.
- **Priority.** Reset has priority over `en_i`, and `en_i` has priority over everything else.

## Timing
- Request-to-grant latency: 1 cycle from IDLE. A request sampled at edge k gives `gnt_o` valid after edge k.
- Slot length is `len_r`+1 enabled cycles. `slot_end_o` coincides with the last of these cycles.
- Hand-over between requesters: 0 idle cycles. The new grant is visible the cycle after `slot_end_o`.
- Early release: `req_i` low in cycle c of a slot makes `slot_end_o`=1 in cycle c, and `gnt_o` changes after edge c.
- Cycles with `en_i` low are not counted toward the slot length.
- `slot_end_o` is combinational from registered state and `req_i`/`en_i`. There is no other combinational input-to-output path.

## Test plan
- **Reset values.** Hold `rst_n_i`=0 for 2 cycles with `req_i`=4'b1111, then release with `req_i`=0. Required: `gnt_o`=0, `busy_o`=0, `cnt_o`=0, `gnt_id_o`=0 while in reset and afterwards.
- **Single requester.** `req_i`=4'b0010 held, `len_i`[1]=3. Required: `gnt_o`=4'b0010 one cycle after the request; `cnt_o` cycles 0,1,2,3,0,1,…; `slot_end_o` high whenever `cnt_o`=3; `gnt_o` never drops.
- **Round robin.** `req_i`=4'b0101 held, all lengths 1. Required grant sequence 0,0,2,2,0,0,2,2 with no gap cycles.
- **Early release.** Requester 3 with `len`=10 drops `req_i`[3] when `cnt_o`=4 while requester 1 is requesting. Required: `slot_end_o` high at `cnt_o`=4, then `gnt_o`=4'b0010 with `cnt_o`=0.
- **Stall.** `en_i` low for 5 cycles at `cnt_o`=2 of a `len`=5 slot. Required: `cnt_o` holds at 2, `slot_end_o` stays 0, and the slot totals 6 enabled cycles.
- **Reset mid-slot.** `len`=0xFFFF with requesters 2 and 3 active; apply reset at `cnt_o`=7. Required: all outputs at reset values. After release, requester 2 wins because `ptr`=0.
